po2_dot_product_driver: RTL and testbench

Upstream/downstream driver for the po2 dot product engine. Collects D serial W-bit activations over a valid/ready stream and packs them into packed_a. Restarts the engine with a one-cycle active-high dp_rst pulse and waits for its held out_v. Requantizes the 2W-bit result back to W bits and emits it on a valid/ready stream to the next layer.

---
 rtl/po2_pkg.sv | 29 ++
 rtl/po2_dot_product_driver_if.sv | 30 +++
 rtl/po2_requantize.sv | 24 ++
 rtl/po2_dot_product_driver.sv | 107 ++++++++++
 tb/tb_po2_dot_product_driver.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/po2_pkg.sv
// Shared types and helpers for the po2 dot product driver:
// FSM state encoding, legal dot product sizes and a width-generic saturate.
package po2_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    LAUNCH  = 2'd1,
    WAIT    = 2'd2,
    EMIT    = 2'd3
  } state_t;

  // Dot product sizes the engine supports.
  function automatic bit legal_d(input int unsigned d);
    return (d == 32'd4) || (d == 32'd8) || (d == 32'd16);
  endfunction

  // Clamp a sign-extended value to the signed range of a w-bit word (w <= 32).
  function automatic logic signed [63:0] saturate(input logic signed [63:0] s,
                                                  input int unsigned     w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 32'd1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 32'd1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/po2_dot_product_driver_if.sv
// Activation stream, engine operand/result and result stream of the po2 driver.
interface po2_dot_product_driver_if #(
  parameter int unsigned W = 16,
  parameter int unsigned D = 4
);

  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           in_ready;
  logic [D*W-1:0] packed_a;
  logic           dp_rst;
  logic [2*W-1:0] dp_out;
  logic           dp_out_v;
  logic [W-1:0]   res_data;
  logic           res_valid;
  logic           res_ready;

  // Environment side: upstream producer, engine and downstream consumer.
  modport master (
    output in_data, in_valid, dp_out, dp_out_v, res_ready,
    input  in_ready, packed_a, dp_rst, res_data, res_valid
  );

  // Driver side.
  modport slave (
    input  in_data, in_valid, dp_out, dp_out_v, res_ready,
    output in_ready, packed_a, dp_rst, res_data, res_valid
  );

endinterface

// File: rtl/po2_requantize.sv
// Requantizes a 2W-bit signed dot product to W bits: arithmetic shift,
// saturation to the W-bit signed range and optional relu.
module po2_requantize
  import po2_pkg::*;
#(
  parameter int unsigned W         = 16,
  parameter int unsigned FRAC_BITS = 8,
  parameter int unsigned RELU      = 0
) (
  input  logic [2*W-1:0] d,
  output logic [W-1:0]   q_c
);

  logic signed [2*W-1:0] s;
  logic signed [63:0]    sat;

  always_comb begin
    s   = $signed(d) >>> FRAC_BITS;
    sat = saturate(64'(s), W);
    q_c = W'(sat);
    if ((RELU != 0) && q_c[W-1]) q_c = '0;
  end

endmodule

// File: rtl/po2_dot_product_driver.sv
// Collects D activations, restarts the po2 dot product engine, waits for its
// result and emits the requantized value downstream; sticky err on timeout.
module po2_dot_product_driver
  import po2_pkg::*;
#(
  parameter int unsigned W            = 16,
  parameter int unsigned D            = 4,
  parameter int unsigned FRAC_BITS    = 8,
  parameter int unsigned RELU         = 0,
  parameter int unsigned WAIT_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  po2_dot_product_driver_if.slave bus,
  output logic                   err
);

  localparam int unsigned IDX_W = $clog2(D);
  localparam int unsigned CNT_W = $clog2(WAIT_TIMEOUT + 1);

  if (!legal_d(D) || (FRAC_BITS > W) || (WAIT_TIMEOUT < 8)) begin : g_bad_param
    $error("po2_dot_product_driver: illegal parameter set");
  end

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     rq_c;

  po2_requantize #(
    .W         (W),
    .FRAC_BITS (FRAC_BITS),
    .RELU      (RELU)
  ) u_requantize (
    .d   (bus.dp_out),
    .q_c (rq_c)
  );

  // Control FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= COLLECT;
      idx           <= '0;
      cnt           <= '0;
      bus.in_ready  <= 1'b0;
      bus.packed_a  <= '0;
      bus.dp_rst    <= 1'b1;
      bus.res_data  <= '0;
      bus.res_valid <= 1'b0;
      err           <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          bus.dp_rst   <= 1'b0;
          bus.in_ready <= 1'b1;
          if (bus.in_valid && bus.in_ready) begin
            // Element 0 lands in the most significant slot.
            for (int i = 0; i < int'(D); i++) begin
              if (idx == IDX_W'(i)) bus.packed_a[(int'(D) - 1 - i)*int'(W) +: W] <= bus.in_data;
            end
            if (idx == IDX_W'(D - 1)) begin
              idx          <= '0;
              state        <= LAUNCH;
              bus.in_ready <= 1'b0;
              bus.dp_rst   <= 1'b1;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end

        LAUNCH: begin
          bus.dp_rst <= 1'b0;
          cnt        <= '0;
          state      <= WAIT;
        end

        WAIT: begin
          if (bus.dp_out_v) begin
            bus.res_data  <= rq_c;
            bus.res_valid <= 1'b1;
            state         <= EMIT;
          end else if (cnt == CNT_W'(WAIT_TIMEOUT - 1)) begin
            // Engine never answered: abandon the vector, no result.
            err          <= 1'b1;
            cnt          <= '0;
            bus.in_ready <= 1'b1;
            state        <= COLLECT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        EMIT: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= COLLECT;
          end
        end

        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_po2_dot_product_driver.sv
// Randomized bench for po2_dot_product_driver with a behavioural engine and
// an arithmetic requantization reference; also checks po2_requantize alone.
module tb_po2_dot_product_driver;

  localparam int unsigned W    = 16;
  localparam int unsigned D    = 4;
  localparam int unsigned FRAC = 8;
  localparam int unsigned TO   = 64;

  int n_tests = 0;
  int n_fail  = 0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        err;
  logic [15:0] vec [4];
  logic [31:0] eng_out = '0;
  logic        eng_v   = 1'b0;
  int          eng_cnt = 0;
  int          eng_lat = 6;
  bit          eng_en  = 1'b1;

  logic [31:0] rq_in = '0;
  logic [15:0] rq0_q;
  logic [15:0] rq1_q;

  po2_dot_product_driver_if #(.W(W), .D(D)) bus ();

  po2_dot_product_driver #(
    .W            (W),
    .D            (D),
    .FRAC_BITS    (FRAC),
    .RELU         (0),
    .WAIT_TIMEOUT (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .err   (err)
  );

  po2_requantize #(.W(16), .FRAC_BITS(8), .RELU(0)) u_rq0 (.d(rq_in), .q_c(rq0_q));
  po2_requantize #(.W(16), .FRAC_BITS(8), .RELU(1)) u_rq1 (.d(rq_in), .q_c(rq1_q));

  always #5 clk = ~clk;

  assign bus.dp_out   = eng_out;
  assign bus.dp_out_v = eng_v;

  // Engine: restarted by dp_rst, raises a held valid eng_lat cycles later.
  always @(posedge clk) begin
    if (bus.dp_rst) begin
      eng_cnt <= 1;
      eng_v   <= 1'b0;
    end else if (eng_en) begin
      eng_cnt <= eng_cnt + 1;
      if (eng_cnt == eng_lat - 1) eng_v <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_rq(input logic [31:0] x, input bit relu);
    longint v;
    longint s;
    v = longint'($signed(x));
    s = v >>> FRAC;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    if (relu && s < 0) s = 0;
    return 16'(s);
  endfunction

  function automatic logic [63:0] ref_packed();
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < 4; i++) p = (p << 16) | 64'(vec[i]);
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers vec[0..num-1] with in_valid held; returns cycles spent waiting on in_ready.
  task automatic send_vec(input int num, output int waits);
    int n;
    waits = 0;
    for (int i = 0; i < num; i++) begin
      bus.in_data  = vec[i];
      bus.in_valid = 1'b1;
      n = 0;
      while (!bus.in_ready && n < 50) begin
        tick();
        n++;
      end
      waits += n;
      if (!bus.in_ready) check("in_ready_wait", 64'(bus.in_ready), 64'd1);
      tick();
      if (i < 3) begin
        check("dp_rst_mid", 64'(bus.dp_rst), 64'd0);
        check("in_ready_mid", 64'(bus.in_ready), 64'd1);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  // Full vector: collect, launch, wait for engine, hold result bp extra cycles, transfer.
  task automatic run_vec(input int bp, input bit chk_b2b);
    int          w;
    int          n;
    logic        prev_v;
    logic [15:0] exp_res;
    logic [63:0] exp_pk;
    exp_pk  = ref_packed();
    exp_res = ref_rq(eng_out, 1'b0);
    send_vec(4, w);
    if (chk_b2b) check("b2b_waits", 64'(w), 64'd0);
    check("packed_a", bus.packed_a, exp_pk);
    check("dp_rst_launch", 64'(bus.dp_rst), 64'd1);
    check("in_ready_launch", 64'(bus.in_ready), 64'd0);
    tick();
    check("dp_rst_wait", 64'(bus.dp_rst), 64'd0);
    n = 1;
    prev_v = bus.dp_out_v;
    while (!bus.res_valid && n < 200) begin
      prev_v = bus.dp_out_v;
      tick();
      n++;
    end
    check("res_latency", 64'(n), 64'(eng_lat + 1));
    check("dp_out_v_before", 64'(prev_v), 64'd1);
    check("res_data", 64'(bus.res_data), 64'(exp_res));
    check("packed_hold", bus.packed_a, exp_pk);
    for (int k = 0; k < bp; k++) begin
      tick();
      check("bp_valid", 64'(bus.res_valid), 64'd1);
      check("bp_data", 64'(bus.res_data), 64'(exp_res));
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("res_valid_drop", 64'(bus.res_valid), 64'd0);
    check("in_ready_back", 64'(bus.in_ready), 64'd1);
  endtask

  task automatic rand_vec();
    for (int i = 0; i < 4; i++) vec[i] = 16'($urandom);
  endtask

  function automatic logic [31:0] rand_dp();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 32'h007F_FFFF));
      2:       return 32'h0 - 32'($urandom_range(0, 32'h0080_0000));
      default: return (($urandom_range(0, 1) != 0) ? 32'h007F_FF00 : 32'hFF80_0000) + 32'($urandom_range(0, 511));
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   w;
    int   n;
    logic saw_rv;

    rst_n         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.res_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_dp_rst", 64'(bus.dp_rst), 64'd1);
    check("rst_packed", bus.packed_a, 64'd0);
    check("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("rst_res_data", 64'(bus.res_data), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("post_rst_dp_rst", 64'(bus.dp_rst), 64'd0);

    // Directed vector with 0x00012345 result and 5 cycles of backpressure.
    vec[0] = 16'h0001; vec[1] = 16'h0002; vec[2] = 16'h0003; vec[3] = 16'h0004;
    eng_out = 32'h0001_2345;
    eng_lat = 6;
    run_vec(5, 1'b0);
    check("err_after_first", 64'(err), 64'd0);

    // Next vector must be accepted back to back.
    rand_vec();
    eng_out = rand_dp();
    run_vec(0, 1'b1);

    // Timeout: engine stays silent.
    rand_vec();
    eng_en = 1'b0;
    send_vec(4, w);
    check("to_dp_rst", 64'(bus.dp_rst), 64'd1);
    n = 0;
    saw_rv = 1'b0;
    while (!err && n < 200) begin
      tick();
      n++;
      if (bus.res_valid) saw_rv = 1'b1;
    end
    check("to_cycles", 64'(n), 64'(TO + 1));
    check("to_in_ready", 64'(bus.in_ready), 64'd1);
    check("to_no_result", 64'(saw_rv), 64'd0);
    eng_en = 1'b1;
    rand_vec();
    eng_out = rand_dp();
    eng_lat = 9;
    run_vec(1, 1'b1);
    check("err_sticky", 64'(err), 64'd1);

    // Asynchronous reset mid-collect after two accepts.
    rand_vec();
    send_vec(2, w);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("mid_rst_dp_rst", 64'(bus.dp_rst), 64'd1);
    check("mid_rst_packed", bus.packed_a, 64'd0);
    check("mid_rst_err", 64'(err), 64'd0);
    repeat (3) @(posedge clk);
    #4 rst_n = 1'b1;
    rand_vec();
    eng_out = rand_dp();
    run_vec(0, 1'b0);

    // Randomized vectors, latencies and backpressure.
    for (int t = 0; t < 20; t++) begin
      rand_vec();
      eng_out = rand_dp();
      eng_lat = $urandom_range(2, 20);
      run_vec($urandom_range(0, 3), 1'b1);
    end
    check("err_final", 64'(err), 64'd0);

    // Standalone requantizer: boundary vectors then random ones.
    rq_in = 32'h7FFF_0000; #1;
    check("rq_pos_sat", 64'(rq0_q), 64'h7FFF);
    check("rq_pos_sat_relu", 64'(rq1_q), 64'h7FFF);
    rq_in = 32'h8000_0000; #1;
    check("rq_neg_sat", 64'(rq0_q), 64'h8000);
    check("rq_neg_sat_relu", 64'(rq1_q), 64'h0000);
    rq_in = 32'hFFFF_FF00; #1;
    check("rq_minus1", 64'(rq0_q), 64'hFFFF);
    check("rq_minus1_relu", 64'(rq1_q), 64'h0000);
    for (int t = 0; t < 20; t++) begin
      rq_in = rand_dp(); #1;
      check("rq_rand", 64'(rq0_q), 64'(ref_rq(rq_in, 1'b0)));
      check("rq_rand_relu", 64'(rq1_q), 64'(ref_rq(rq_in, 1'b1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
